store_be_buffer: RTL and testbench
==================================

Name: store_be_buffer

Overview:
- Store-side counterpart of the load data extractor. Takes store requests (sb/sh/sw) from the M stage and checks them for AdES.
- Each legal store is turned into a word-aligned address, a 4-bit byte enable and lane-positioned write data, then queued in a small FIFO.
- The FIFO drains to the data-memory/bridge bus through a valid/ready handshake.
- The `pending` output tells hazard logic that stores are still in flight, so loads stall until the buffer is empty.

Parameters:
- DEPTH, 4, number of FIFO entries; must be a power of 2 and ≥2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high; clears all state
- st_valid  input  1  M stage presents a request this cycle
- st_instrType  input  10  instruction type; encodings from instr_def_h.v (`sb`, `sh`, `sw`)
- st_addr  input  32  byte address (ALU result)
- st_data  input  32  rt value, unshifted
- st_ready  output  1  buffer can accept a store; equals !full
- st_exc  output  1  AdES detected on the current request (combinational)
- pending  output  1  buffer is non-empty
- mem_valid  output  1  head entry is valid
- mem_addr  output  32  head word address; bits [1:0] are always 0
- mem_be  output  4  head byte enable
- mem_wdata  output  32  head data, lane-shifted; lanes without enable are 0
- mem_ready  input  1  sink accepts the head entry this cycle

Behaviour:
- Reset: FIFO empty, head and tail pointers 0, count 0. mem_valid=0, mem_addr=0, mem_be=0, mem_wdata=0, pending=0, st_ready=1. Reset mid-drain discards every queued entry.
- Lane formatting:
  - sw: be=4'b1111, wdata=st_data.
  - sh: be=4'b0011 if addr[1]=0, else 4'b1100; st_data[15:0] placed in lanes [15:0] or [31:16].
  - sb: be=1<<addr[1:0]; st_data[7:0] placed in lane addr[1:0].
- AdES (st_exc=1 only when st_valid and st_instrType is a store):
  - sw with addr[1:0]≠0.
  - sh with addr[0]=1.
  - Address outside every legal range: DM 0x0000_0000–0x0000_2FFF, TC0 0x0000_7F00–0x0000_7F0B, TC1 0x0000_7F10–0x0000_7F1B, IG 0x0000_7F20–0x0000_7F23.
  - sh or sb to TC0/TC1.
  - Any store to 0x0000_7F08 or 0x0000_7F18 (read-only count registers).
  - Range checks use addr plus access size minus 1, so no access may straddle a range end.
- Enqueue: happens when st_valid & st_ready & is_store & !st_exc. The entry is written at the tail on that edge, the tail wraps modulo DEPTH, and count increments.
  - A faulting or non-store request leaves the FIFO unchanged.
  - st_exc does not depend on st_ready.
- Dequeue: happens on mem_valid & mem_ready. The head advances (wrap modulo DEPTH) and count decrements.
  - mem_* come from registered head storage. When empty, mem_be and mem_wdata read 0.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
  - When full, st_ready=0 even if mem_ready=1 in the same cycle; there is no same-cycle pass-through.
- Latency: an accepted store appears on mem_valid one cycle later at minimum.
- Ordering: strictly FIFO; no merging and no reordering.
- pending = (count≠0); it is registered-derived and has no combinational path from st_valid.
- Handshake rules: mem_valid never drops while mem_ready=0. The head fields stay stable until accepted.

Optional Feature:
- Macro STORE_BYPASS_EN.
- Defined: when the FIFO is empty, mem_ready=1 and a legal store is offered, the store drives mem_valid/mem_addr/mem_be/mem_wdata combinationally in the same cycle and is consumed without entering the FIFO. pending stays 0. If mem_ready=0 in that case, the store enqueues normally.
- Not defined: every store goes through the FIFO, giving a minimum latency of 1.

Test Plan:
- sb addr=0x0000_0013, data=0xAABBCCDD, mem_ready=1 → next cycle mem_valid=1, mem_addr=0x0000_0010, mem_be=4'b1000, mem_wdata=0xDD00_0000; pending 1 for one cycle, then 0.
- sh addr=0x0000_0022, data=0x1234_5678 → mem_be=4'b1100, mem_wdata=0x5678_0000. sh addr=0x0000_0021 → st_exc=1, no enqueue, pending stays 0.
- mem_ready=0; issue DEPTH sw stores to 0x0, 0x4, 0x8, 0xC → st_ready falls after the 4th. A 5th store offered with mem_ready=1 that same cycle is refused. Drain in order 0x0, 0x4, 0x8, 0xC, each with be=4'b1111.
- sw to 0x0000_7F08 → st_exc=1. sb to 0x0000_7F00 → st_exc=1. sw to 0x0000_3000 → st_exc=1. sw to 0x0000_7F04 → accepted.
- Fill 3 entries, pulse reset while mem_ready=1 → next cycle mem_valid=0, pending=0, st_ready=1; the entries are never presented.
- With STORE_BYPASS_EN: empty FIFO, mem_ready=1, sw 0x100 with data 0xCAFEF00D → same cycle mem_valid=1, mem_addr=0x100, mem_wdata=0xCAFEF00D; next cycle mem_valid=0.

Source files
------------

// File: rtl/store_be_buffer_if.sv
// Store request and data-memory write bus bundle for store_be_buffer.
interface store_be_buffer_if;
    logic        st_valid;
    logic [9:0]  st_instrType;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        st_exc;
    logic        pending;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;

    modport slave (
        input  st_valid, st_instrType, st_addr, st_data, mem_ready,
        output st_ready, st_exc, pending, mem_valid, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output st_valid, st_instrType, st_addr, st_data, mem_ready,
        input  st_ready, st_exc, pending, mem_valid, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/store_be_buffer.sv
// Store buffer: AdES check, byte-lane formatting and a FIFO draining to the data bus.
// Optional macro STORE_BYPASS_EN lets a legal store pass straight through an empty, ready buffer.
module store_be_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [9:0]  INSTR_SB = 10'h028,
    parameter logic [9:0]  INSTR_SH = 10'h029,
    parameter logic [9:0]  INSTR_SW = 10'h02B
) (
    input logic           clk,
    input logic           reset,
    store_be_buffer_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0] head, tail;
    logic [AW:0]   count;
    logic [31:0]   q_addr  [DEPTH];
    logic [3:0]    q_be    [DEPTH];
    logic [31:0]   q_wdata [DEPTH];

    logic        is_sb, is_sh, is_sw, is_store;
    logic [1:0]  size_m1;
    logic [32:0] last;
    logic        in_dm, in_tc, in_ig, misalign, ro_reg, exc;
    logic [31:0] f_addr, f_wdata, lane_mask;
    logic [3:0]  f_be;
    logic        legal, full, head_valid, bypass, enq, deq;

    function automatic logic in_rng(input logic [31:0] a, input logic [32:0] l,
                                    input logic [31:0] lo, input logic [31:0] hi);
        return (a >= lo) && (l <= {1'b0, hi});
    endfunction

    always_comb begin
        is_sb    = (bus.st_instrType == INSTR_SB);
        is_sh    = (bus.st_instrType == INSTR_SH);
        is_sw    = (bus.st_instrType == INSTR_SW);
        is_store = is_sb | is_sh | is_sw;
        size_m1  = is_sw ? 2'd3 : (is_sh ? 2'd1 : 2'd0);
        // 33-bit end address so a wrap past 0xFFFF_FFFF cannot look in range
        last     = {1'b0, bus.st_addr} + {31'd0, size_m1};
        in_dm    = in_rng(bus.st_addr, last, 32'h0000_0000, 32'h0000_2FFF);
        in_tc    = in_rng(bus.st_addr, last, 32'h0000_7F00, 32'h0000_7F0B)
                 | in_rng(bus.st_addr, last, 32'h0000_7F10, 32'h0000_7F1B);
        in_ig    = in_rng(bus.st_addr, last, 32'h0000_7F20, 32'h0000_7F23);
        misalign = (is_sw & (bus.st_addr[1:0] != 2'b00)) | (is_sh & bus.st_addr[0]);
        ro_reg   = (bus.st_addr[31:2] == 30'h0000_1FC2) | (bus.st_addr[31:2] == 30'h0000_1FC6);
        exc      = bus.st_valid & is_store &
                   (misalign | !(in_dm | in_tc | in_ig) | ((is_sh | is_sb) & in_tc) | ro_reg);
    end

    always_comb begin
        f_addr  = {bus.st_addr[31:2], 2'b00};
        f_be    = 4'b0000;
        f_wdata = '0;
        if (is_sw) begin
            f_be    = 4'b1111;
            f_wdata = bus.st_data;
        end else if (is_sh) begin
            f_be    = bus.st_addr[1] ? 4'b1100 : 4'b0011;
            f_wdata = {2{bus.st_data[15:0]}};
        end else if (is_sb) begin
            f_be    = 4'b0001 << bus.st_addr[1:0];
            f_wdata = {4{bus.st_data[7:0]}};
        end
        lane_mask = {{8{f_be[3]}}, {8{f_be[2]}}, {8{f_be[1]}}, {8{f_be[0]}}};
        f_wdata   = f_wdata & lane_mask;
    end

    assign full       = (count == (AW + 1)'(DEPTH));
    assign head_valid = (count != '0);
    assign legal      = bus.st_valid & is_store & !exc;

`ifdef STORE_BYPASS_EN
    assign bypass = !head_valid & bus.mem_ready & legal;
`else
    assign bypass = 1'b0;
`endif

    assign enq = legal & !full & !bypass;
    assign deq = head_valid & bus.mem_ready;

    assign bus.st_ready = !full;
    assign bus.st_exc   = exc;
    assign bus.pending  = head_valid;

    always_comb begin
        bus.mem_valid = head_valid;
        bus.mem_addr  = head_valid ? q_addr[head]  : '0;
        bus.mem_be    = head_valid ? q_be[head]    : '0;
        bus.mem_wdata = head_valid ? q_wdata[head] : '0;
        if (bypass) begin
            bus.mem_valid = 1'b1;
            bus.mem_addr  = f_addr;
            bus.mem_be    = f_be;
            bus.mem_wdata = f_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                q_addr[i]  <= '0;
                q_be[i]    <= '0;
                q_wdata[i] <= '0;
            end
        end else begin
            if (enq) begin
                q_addr[tail]  <= f_addr;
                q_be[tail]    <= f_be;
                q_wdata[tail] <= f_wdata;
                tail          <= tail + 1'b1;
            end
            if (deq) begin
                head <= head + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_store_be_buffer.sv
// Directed self-checking bench for store_be_buffer (default build; bypass case under STORE_BYPASS_EN).
module tb_store_be_buffer;
    localparam logic [9:0] SB = 10'h028;
    localparam logic [9:0] SH = 10'h029;
    localparam logic [9:0] SW = 10'h02B;
    localparam logic [9:0] LW = 10'h023;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    store_be_buffer_if bus ();

    store_be_buffer #(
        .DEPTH    (4),
        .INSTR_SB (SB),
        .INSTR_SH (SH),
        .INSTR_SW (SW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [9:0] t, input logic [31:0] a, input logic [31:0] d);
        bus.st_valid     = v;
        bus.st_instrType = t;
        bus.st_addr      = a;
        bus.st_data      = d;
    endtask

    typedef struct {
        logic [9:0]  t;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] ea;
        logic [3:0]  ebe;
        logic [31:0] ew;
    } fmt_vec_t;

    typedef struct {
        logic        v;
        logic [9:0]  t;
        logic [31:0] a;
        logic        eexc;
    } exc_vec_t;

    fmt_vec_t fv[6];
    exc_vec_t ev[14];

    initial begin
        checks = 0;
        errors = 0;
        fv[0] = '{SB, 32'h0000_0013, 32'hAABB_CCDD, 32'h0000_0010, 4'b1000, 32'hDD00_0000};
        fv[1] = '{SB, 32'h0000_0001, 32'h1122_3344, 32'h0000_0000, 4'b0010, 32'h0000_4400};
        fv[2] = '{SH, 32'h0000_0022, 32'h1234_5678, 32'h0000_0020, 4'b1100, 32'h5678_0000};
        fv[3] = '{SH, 32'h0000_2FFE, 32'hCAFE_BEEF, 32'h0000_2FFC, 4'b1100, 32'hBEEF_0000};
        fv[4] = '{SW, 32'h0000_7F04, 32'h0000_00FF, 32'h0000_7F04, 4'b1111, 32'h0000_00FF};
        fv[5] = '{SH, 32'h0000_7F20, 32'h0000_A5C3, 32'h0000_7F20, 4'b0011, 32'h0000_A5C3};

        ev[0]  = '{1'b1, SH, 32'h0000_0021, 1'b1};
        ev[1]  = '{1'b1, SW, 32'h0000_7F08, 1'b1};
        ev[2]  = '{1'b1, SB, 32'h0000_7F00, 1'b1};
        ev[3]  = '{1'b1, SW, 32'h0000_3000, 1'b1};
        ev[4]  = '{1'b1, SW, 32'h0000_2FFE, 1'b1};
        ev[5]  = '{1'b1, SH, 32'h0000_7F10, 1'b1};
        ev[6]  = '{1'b1, SW, 32'h0000_7F18, 1'b1};
        ev[7]  = '{1'b1, SW, 32'h0000_7F0C, 1'b1};
        ev[8]  = '{1'b1, SW, 32'h0000_7F24, 1'b1};
        ev[9]  = '{1'b1, SW, 32'h0000_2FFC, 1'b0};
        ev[10] = '{1'b1, SB, 32'h0000_7F23, 1'b0};
        ev[11] = '{1'b1, SH, 32'h0000_7F22, 1'b0};
        ev[12] = '{1'b0, SW, 32'h0000_3000, 1'b0};
        ev[13] = '{1'b1, LW, 32'h0000_3000, 1'b0};

        reset         = 1'b1;
        bus.mem_ready = 1'b0;
        drive(1'b0, 10'd0, 32'd0, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        check("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
        check("rst_pending",   32'(bus.pending),   32'd0);
        check("rst_st_ready",  32'(bus.st_ready),  32'd1);
        check("rst_mem_addr",  bus.mem_addr,       32'd0);
        check("rst_mem_be",    32'(bus.mem_be),    32'd0);
        check("rst_mem_wdata", bus.mem_wdata,      32'd0);

`ifndef STORE_BYPASS_EN
        // sb with sink ready: one cycle latency, pending for exactly one cycle
        bus.mem_ready = 1'b1;
        drive(1'b1, SB, 32'h0000_0013, 32'hAABB_CCDD);
        #1;
        check("sb_exc0",       32'(bus.st_exc),    32'd0);
        check("sb_no_bypass",  32'(bus.mem_valid), 32'd0);
        tick();
        drive(1'b0, 10'd0, 32'd0, 32'd0);
        check("sb_valid",      32'(bus.mem_valid), 32'd1);
        check("sb_addr",       bus.mem_addr,       32'h0000_0010);
        check("sb_be",         32'(bus.mem_be),    32'h8);
        check("sb_wdata",      bus.mem_wdata,      32'hDD00_0000);
        check("sb_pending",    32'(bus.pending),   32'd1);
        tick();
        check("sb_pending_clr", 32'(bus.pending),  32'd0);
        check("sb_valid_clr",   32'(bus.mem_valid), 32'd0);
`else
        bus.mem_ready = 1'b1;
        drive(1'b1, SW, 32'h0000_0100, 32'hCAFE_F00D);
        #1;
        check("byp_valid",   32'(bus.mem_valid), 32'd1);
        check("byp_addr",    bus.mem_addr,       32'h0000_0100);
        check("byp_wdata",   bus.mem_wdata,      32'hCAFE_F00D);
        check("byp_pending", 32'(bus.pending),   32'd0);
        tick();
        drive(1'b0, 10'd0, 32'd0, 32'd0);
        #1;
        check("byp_valid_clr",   32'(bus.mem_valid), 32'd0);
        check("byp_pending_clr", 32'(bus.pending),   32'd0);
`endif

        // lane formatting: enqueue with sink stalled, inspect head, hold, then pop
        foreach (fv[i]) begin
            bus.mem_ready = 1'b0;
            drive(1'b1, fv[i].t, fv[i].a, fv[i].d);
            tick();
            drive(1'b0, 10'd0, 32'd0, 32'd0);
            check($sformatf("fmt%0d_addr", i),  bus.mem_addr,       fv[i].ea);
            check($sformatf("fmt%0d_be", i),    32'(bus.mem_be),    32'(fv[i].ebe));
            check($sformatf("fmt%0d_wdata", i), bus.mem_wdata,      fv[i].ew);
            tick();
            check($sformatf("fmt%0d_hold", i),  bus.mem_wdata,      fv[i].ew);
            check($sformatf("fmt%0d_held_valid", i), 32'(bus.mem_valid), 32'd1);
            bus.mem_ready = 1'b1;
            tick();
            check($sformatf("fmt%0d_drained", i), 32'(bus.pending), 32'd0);
        end

        // AdES decode; faulting requests see a clock edge and must not enqueue
        bus.mem_ready = 1'b0;
        foreach (ev[i]) begin
            drive(ev[i].v, ev[i].t, ev[i].a, 32'h5A5A_5A5A);
            #1;
            check($sformatf("exc%0d_%08h", i, ev[i].a), 32'(bus.st_exc), 32'(ev[i].eexc));
            if (!ev[i].eexc) bus.st_valid = 1'b0;
            tick();
            check($sformatf("exc%0d_noenq", i), 32'(bus.pending), 32'd0);
        end
        drive(1'b0, 10'd0, 32'd0, 32'd0);

        // fill to DEPTH, refuse a fifth store while the head pops, drain in order
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, SW, 32'(4 * i), 32'h1000 + 32'(i));
            #1;
            check($sformatf("fill%0d_ready", i), 32'(bus.st_ready), 32'd1);
            tick();
        end
        drive(1'b1, SW, 32'h0000_0010, 32'hDEAD_0005);
        bus.mem_ready = 1'b1;
        #1;
        check("full_ready", 32'(bus.st_ready), 32'd0);
        check("full_head",  bus.mem_addr,      32'h0000_0000);
        tick();
        drive(1'b0, 10'd0, 32'd0, 32'd0);
        for (int i = 1; i < 4; i++) begin
            check($sformatf("drain%0d_addr", i),  bus.mem_addr,    32'(4 * i));
            check($sformatf("drain%0d_be", i),    32'(bus.mem_be), 32'hF);
            check($sformatf("drain%0d_wdata", i), bus.mem_wdata,   32'h1000 + 32'(i));
            tick();
        end
        check("drain_empty", 32'(bus.mem_valid), 32'd0);

        // simultaneous push and pop keeps one entry in flight
        bus.mem_ready = 1'b0;
        drive(1'b1, SW, 32'h0000_0040, 32'h0000_0040);
        tick();
        bus.mem_ready = 1'b1;
        drive(1'b1, SW, 32'h0000_0044, 32'h0000_0044);
        tick();
        drive(1'b0, 10'd0, 32'd0, 32'd0);
        check("swap_addr",    bus.mem_addr,      32'h0000_0044);
        check("swap_pending", 32'(bus.pending),  32'd1);
        tick();
        check("swap_empty",   32'(bus.pending),  32'd0);

        // reset mid-drain discards queued entries
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, SW, 32'h0000_0080 + 32'(4 * i), 32'hBEEF_0000 + 32'(i));
            tick();
        end
        drive(1'b0, 10'd0, 32'd0, 32'd0);
        check("pre_rst_pending", 32'(bus.pending), 32'd1);
        bus.mem_ready = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_valid",   32'(bus.mem_valid), 32'd0);
        check("mid_rst_pending", 32'(bus.pending),   32'd0);
        check("mid_rst_ready",   32'(bus.st_ready),  32'd1);
        tick();
        check("post_rst_valid",  32'(bus.mem_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
